// File: rtl/snoop_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snoop_bus_pkg
// Purpose  : Shared encodings for the snoop bus sequencer: bus roles, MESI
//            bus commands and the sequencer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package snoop_bus_pkg;

    // Role field of bus_signals, upper two bits per L1
    localparam logic [1:0] ROLE_IDLE  = 2'b00;
    localparam logic [1:0] ROLE_REQ   = 2'b01;
    localparam logic [1:0] ROLE_SNOOP = 2'b10;

    // Command field of bus_signals, lower three bits per L1
    localparam logic [2:0] BUS_IDLE = 3'b000;
    localparam logic [2:0] BUS_RD   = 3'b100;
    localparam logic [2:0] BUS_RDX  = 3'b010;
    localparam logic [2:0] BUS_UPGR = 3'b001;  // reserved, never issued

    typedef enum logic [2:0] {
        SB_IDLE        = 3'd0,
        SB_SNOOP_START = 3'd1,
        SB_SNOOP_WAIT  = 3'd2,
        SB_REQ_START   = 3'd3,
        SB_REQ_WAIT    = 3'd4,
        SB_DONE        = 3'd5
    } sb_state_e;

    // Bus command implied by the access type of the requester
    function automatic logic [2:0] bus_cmd(input logic is_write);
        return is_write ? BUS_RDX : BUS_RD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snoop_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : snoop_rr_arbiter
// Purpose  : Combinational arbiter: request vector + search pointer in,
//            one-hot grant and grant index out.
//            SNOOP_ARB_RR_EN defined   -> round-robin starting at ptr_i.
//            SNOOP_ARB_RR_EN undefined -> fixed priority, lowest index wins.
// Revision : 1.0 - initial release
// ============================================================================
module snoop_rr_arbiter
    import snoop_bus_pkg::*;
#(
    parameter int NCORE = 4,
    parameter int IDX_W = 2
) (
    input  logic [NCORE-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NCORE-1:0] gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             any_o
);

    logic w_found;
    int   w_k;

    assign any_o = |req_i;

`ifdef SNOOP_ARB_RR_EN
    // Rotating search: first requester at or after the pointer, modulo NCORE
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        w_found   = 1'b0;
        w_k       = 0;
        for (int i = 0; i < NCORE; i++) begin
            w_k = int'(ptr_i) + i;
            if (w_k >= NCORE) w_k = w_k - NCORE;
            if (!w_found && req_i[w_k]) begin
                w_found        = 1'b1;
                gnt_o[w_k]     = 1'b1;
                gnt_idx_o      = IDX_W'(w_k);
            end
        end
    end
`else
    // Pointer has no meaning under fixed priority
    logic w_unused_ptr;
    assign w_unused_ptr = ^ptr_i;

    // Fixed priority search: lowest requesting index wins
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        w_found   = 1'b0;
        w_k       = 0;
        for (int i = 0; i < NCORE; i++) begin
            w_k = i;
            if (!w_found && req_i[w_k]) begin
                w_found    = 1'b1;
                gnt_o[w_k] = 1'b1;
                gnt_idx_o  = IDX_W'(w_k);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/snoop_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : snoop_bus_ctrl
// Purpose  : Snoop bus sequencer. Grants one core, broadcasts the MESI bus
//            command to the snooping L1s, collects their copy flags, then runs
//            the requester's L1 lookup with the resolved other_copy.
//            Optional macro SNOOP_ARB_RR_EN selects round-robin arbitration
//            (default build: fixed priority, no pointer register).
// Revision : 1.0 - initial release
// ============================================================================
module snoop_bus_ctrl
    import snoop_bus_pkg::*;
#(
    parameter int NCORE   = 4,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 20,
    localparam int IDX_W  = (NCORE > 1) ? $clog2(NCORE) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NCORE-1:0]   req_i,
    input  logic [NCORE-1:0]   req_write_i,
    input  logic [NCORE-1:0]   l1_updated_i,
    input  logic [NCORE-1:0]   l1_copy_i,
    output logic [NCORE-1:0]   find_start_o,
    output logic [NCORE-1:0]   ins_type_o,
    output logic [5*NCORE-1:0] bus_signals_o,
    output logic               other_copy_o,
    output logic [NCORE-1:0]   ack_o,
    output logic               ack_err_o,
    output logic [IDX_W-1:0]   grant_id_o,
    output logic               busy_o,
    output logic [CNT_W-1:0]   txn_count_o
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    sb_state_e        state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic             write_q, write_d;
    logic [NCORE-1:0] copy_q, copy_d;
    logic [NCORE-1:0] upd_q, upd_d;
    logic             other_copy_q, other_copy_d;
    logic             err_q, err_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IDX_W-1:0] w_ptr;
    logic [NCORE-1:0] w_arb_gnt;
    logic [IDX_W-1:0] w_arb_idx;
    logic             w_arb_any;
    logic [NCORE-1:0] w_grant_oh;
    logic [NCORE-1:0] w_snoop_mask;
    logic [NCORE-1:0] w_upd_seen;
    logic [NCORE-1:0] w_copy_seen;
    logic             w_timeout;
    logic [2:0]       w_cmd;
    logic             w_snoop_phase;
    logic             w_req_phase;

    assign w_grant_oh    = NCORE'(1) << grant_q;
    assign w_snoop_mask  = ~w_grant_oh;
    // Collectors only ever accumulate snooper pulses; requester pulses drop out here
    assign w_upd_seen    = upd_q  | (l1_updated_i & w_snoop_mask);
    assign w_copy_seen   = copy_q | (l1_copy_i    & w_snoop_mask);
    assign w_timeout     = (timer_q == TW'(TIMEOUT - 1));
    assign w_cmd         = bus_cmd(write_q);
    assign w_snoop_phase = (state_q == SB_SNOOP_START) || (state_q == SB_SNOOP_WAIT);
    assign w_req_phase   = (state_q == SB_REQ_START)   || (state_q == SB_REQ_WAIT);

    assign other_copy_o = other_copy_q;
    assign grant_id_o   = grant_q;
    assign txn_count_o  = cnt_q;

    snoop_rr_arbiter #(
        .NCORE (NCORE),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i     (req_i),
        .ptr_i     (w_ptr),
        .gnt_o     (w_arb_gnt),
        .gnt_idx_o (w_arb_idx),
        .any_o     (w_arb_any)
    );

`ifdef SNOOP_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Search resumes one past the last owner, advanced on every completion
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == SB_DONE) begin
            ptr_d = (grant_q == IDX_W'(NCORE - 1)) ? '0 : grant_q + 1'b1;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    assign w_ptr = ptr_q;
`else
    assign w_ptr = '0;
`endif

    // Sequencer state and transaction context registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= SB_IDLE;
            grant_q      <= '0;
            write_q      <= 1'b0;
            copy_q       <= '0;
            upd_q        <= '0;
            other_copy_q <= 1'b0;
            err_q        <= 1'b0;
            timer_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            write_q      <= write_d;
            copy_q       <= copy_d;
            upd_q        <= upd_d;
            other_copy_q <= other_copy_d;
            err_q        <= err_d;
            timer_q      <= timer_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state logic and per-L1 bus outputs decoded from the current state
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        write_d       = write_q;
        copy_d        = copy_q;
        upd_d         = upd_q;
        other_copy_d  = other_copy_q;
        err_d         = err_q;
        timer_d       = timer_q;
        cnt_d         = cnt_q;
        find_start_o  = '0;
        ack_o         = '0;
        ack_err_o     = 1'b0;
        busy_o        = w_snoop_phase || w_req_phase;
        ins_type_o    = '0;
        bus_signals_o = {NCORE{ROLE_IDLE, BUS_IDLE}};

        case (state_q)
            SB_IDLE: begin
                if (w_arb_any) begin
                    grant_d      = w_arb_idx;
                    write_d      = |(req_write_i & w_arb_gnt);
                    copy_d       = '0;
                    upd_d        = '0;
                    other_copy_d = 1'b0;
                    err_d        = 1'b0;
                    timer_d      = '0;
                    state_d      = (NCORE == 1) ? SB_REQ_START : SB_SNOOP_START;
                end
            end
            SB_SNOOP_START: begin
                find_start_o = w_snoop_mask;
                timer_d      = '0;
                state_d      = SB_SNOOP_WAIT;
            end
            SB_SNOOP_WAIT: begin
                upd_d  = w_upd_seen;
                copy_d = w_copy_seen;
                if (w_upd_seen == w_snoop_mask) begin
                    other_copy_d = |w_copy_seen;
                    state_d      = SB_REQ_START;
                end else if (w_timeout) begin
                    err_d        = 1'b1;
                    other_copy_d = 1'b0;
                    state_d      = SB_DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            SB_REQ_START: begin
                find_start_o = w_grant_oh;
                timer_d      = '0;
                state_d      = SB_REQ_WAIT;
            end
            SB_REQ_WAIT: begin
                if (|(l1_updated_i & w_grant_oh)) begin
                    state_d = SB_DONE;
                end else if (w_timeout) begin
                    err_d        = 1'b1;
                    other_copy_d = 1'b0;
                    state_d      = SB_DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            SB_DONE: begin
                ack_o     = w_grant_oh;
                ack_err_o = err_q;
                cnt_d     = cnt_q + 1'b1;
                state_d   = SB_IDLE;
            end
            default: state_d = SB_IDLE;
        endcase

        if (busy_o) ins_type_o = {NCORE{write_q}};

        for (int i = 0; i < NCORE; i++) begin
            if (w_snoop_phase && w_snoop_mask[i]) begin
                bus_signals_o[5*i +: 5] = {ROLE_SNOOP, w_cmd};
            end else if (w_req_phase && w_grant_oh[i]) begin
                bus_signals_o[5*i +: 5] = {ROLE_REQ, w_cmd};
            end
        end
    end

endmodule
`default_nettype wire
